// File: rtl/jogo_desafio_memoria.sv
// jogo_desafio_memoria
// Simon-style memory game for a 1 kHz board clock. Each round replays a stored
// sequence of one-hot LED steps (one step longer per round), then waits for the
// player to reproduce it on four buttons. Ends in win after the last round, or
// loss on a wrong button or a 5 s (5000-cycle) timeout.
//
// Ports:
//   clock            system clock, 1 kHz, rising edge
//   reset            asynchronous, active-low
//   jogar            start/restart request (level-sampled)
//   chaveMemoria     ROM select, latched on start
//   botaoDificuldade difficulty (0: 8 rounds, 1: 16 rounds), latched on start
//   botoes[3:0]      player buttons, one-hot, active-high
//   leds[3:0]        step display
//   ganhou/perdeu/pronto/timeout  registered end-of-game flags
//   db_*             debug: 7-seg (gfedcba, active-low) views and raw mirrors
module jogo_desafio_memoria (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       chaveMemoria,
  input  logic       botaoDificuldade,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic       timeout,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_limite,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada,
  output logic       db_igual,
  output logic       db_dificuldade,
  output logic       db_sel_memoria,
  output logic [1:0] db_selMux
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    MOSTRA         = 4'h2,
    APAGA          = 4'h3,
    ESPERA         = 4'h4,
    REGISTRA       = 4'h5,
    COMPARA        = 4'h6,
    PROXIMA_JOGADA = 4'h7,
    FIM_RODADA     = 4'h8,
    EST_GANHOU     = 4'hA,
    EST_PERDEU     = 4'hB,
    EST_TIMEOUT    = 4'hC
  } estado_t;

  estado_t     estado, proximo;
  logic [3:0]  addr;
  logic [3:0]  rodada;
  logic [3:0]  jogadafeita;
  logic        sel_memoria;
  logic        dificuldade;
  logic        botoes_prev;
  logic [8:0]  cnt_exibe;
  logic [12:0] cnt_timeout;
  logic [1:0]  sel_mux;

  logic [3:0]  rom_dado;
  logic [3:0]  limite;
  logic        tem_jogada;
  logic        igual;
  logic        fim_exibe;
  logic        fim_timeout;

  function automatic logic [3:0] rom1(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'd0:  r = 4'h1;
      4'd1:  r = 4'h4;
      4'd2:  r = 4'h2;
      4'd3:  r = 4'h8;
      4'd4:  r = 4'h4;
      4'd5:  r = 4'h2;
      4'd6:  r = 4'h1;
      4'd7:  r = 4'h1;
      4'd8:  r = 4'h2;
      4'd9:  r = 4'h2;
      4'd10: r = 4'h4;
      4'd11: r = 4'h4;
      4'd12: r = 4'h8;
      4'd13: r = 4'h8;
      4'd14: r = 4'h1;
      default: r = 4'h4;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] rom0(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'd0:  r = 4'h8;
      4'd1:  r = 4'h4;
      4'd2:  r = 4'h2;
      4'd3:  r = 4'h1;
      4'd4:  r = 4'h1;
      4'd5:  r = 4'h2;
      4'd6:  r = 4'h4;
      4'd7:  r = 4'h8;
      4'd8:  r = 4'h2;
      4'd9:  r = 4'h8;
      4'd10: r = 4'h4;
      4'd11: r = 4'h1;
      4'd12: r = 4'h8;
      4'd13: r = 4'h1;
      4'd14: r = 4'h2;
      default: r = 4'h4;
    endcase
    return r;
  endfunction

  // Hex digit to 7-segment, gfedcba order, active-low.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return ~s;
  endfunction

  assign rom_dado    = sel_memoria ? rom1(addr) : rom0(addr);
  assign limite      = dificuldade ? 4'hF : 4'h7;
  // One-cycle pulse on the rising edge of "any button pressed", so a button
  // held across states only ever produces a single play.
  assign tem_jogada  = (|botoes) & ~botoes_prev;
  assign igual       = (jogadafeita == rom_dado);
  assign fim_exibe   = (cnt_exibe == 9'd499);
  assign fim_timeout = (cnt_timeout == 13'd4999);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    sel_mux = 2'b00;
    case (estado)
      INICIAL:        if (jogar) proximo = PREPARACAO;
      PREPARACAO:     proximo = MOSTRA;
      MOSTRA: begin
        sel_mux = 2'b01;
        if (fim_exibe) proximo = APAGA;
      end
      APAGA:          if (fim_exibe) proximo = (addr == rodada) ? ESPERA : MOSTRA;
      ESPERA: begin
        sel_mux = 2'b10;
        // A play arriving on the expiry cycle takes precedence.
        if (tem_jogada)       proximo = REGISTRA;
        else if (fim_timeout) proximo = EST_TIMEOUT;
      end
      REGISTRA:       proximo = COMPARA;
      COMPARA: begin
        if (!igual)              proximo = EST_PERDEU;
        else if (addr == rodada) proximo = FIM_RODADA;
        else                     proximo = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA;
      FIM_RODADA:     proximo = (rodada == limite) ? EST_GANHOU : MOSTRA;
      EST_GANHOU: begin
        sel_mux = 2'b11;
        if (jogar) proximo = PREPARACAO;
      end
      EST_PERDEU:     if (jogar) proximo = PREPARACAO;
      EST_TIMEOUT:    if (jogar) proximo = PREPARACAO;
      default:        proximo = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr        <= '0;
      rodada      <= '0;
      jogadafeita <= '0;
      sel_memoria <= 1'b0;
      dificuldade <= 1'b0;
      botoes_prev <= 1'b0;
      cnt_exibe   <= '0;
      cnt_timeout <= '0;
      ganhou      <= 1'b0;
      perdeu      <= 1'b0;
      pronto      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      botoes_prev <= |botoes;

      // Display timer wraps to 0 on each mostra/apaga boundary.
      if ((estado == MOSTRA || estado == APAGA) && !fim_exibe)
        cnt_exibe <= cnt_exibe + 9'd1;
      else
        cnt_exibe <= '0;

      if (estado == ESPERA) cnt_timeout <= cnt_timeout + 13'd1;
      else                  cnt_timeout <= '0;

      case (estado)
        PREPARACAO: begin
          sel_memoria <= chaveMemoria;
          dificuldade <= botaoDificuldade;
          rodada      <= '0;
          addr        <= '0;
        end
        APAGA: if (fim_exibe) addr <= (addr == rodada) ? 4'd0 : addr + 4'd1;
        ESPERA: if (tem_jogada) jogadafeita <= botoes;
        PROXIMA_JOGADA: addr <= addr + 4'd1;
        FIM_RODADA: if (rodada != limite) begin
          rodada <= rodada + 4'd1;
          addr   <= '0;
        end
        default: ;
      endcase

      // Flags decoded from the next state so they line up with the state register.
      ganhou  <= (proximo == EST_GANHOU);
      perdeu  <= (proximo == EST_PERDEU) || (proximo == EST_TIMEOUT);
      timeout <= (proximo == EST_TIMEOUT);
      pronto  <= (proximo == EST_GANHOU) || (proximo == EST_PERDEU) ||
                 (proximo == EST_TIMEOUT);
    end
  end

  always_comb begin
    leds = 4'b0000;
    case (sel_mux)
      2'b01:   leds = rom_dado;
      2'b10:   leds = botoes;
      2'b11:   leds = 4'b1111;
      default: leds = 4'b0000;
    endcase
  end

  assign db_contagem    = hex7seg(addr);
  assign db_memoria     = hex7seg(rom_dado);
  assign db_estado      = hex7seg(estado);
  assign db_jogadafeita = hex7seg(jogadafeita);
  assign db_limite      = hex7seg(rodada);
  assign db_clock       = clock;
  assign db_iniciar     = jogar;
  assign db_tem_jogada  = tem_jogada;
  assign db_igual       = igual;
  assign db_dificuldade = dificuldade;
  assign db_sel_memoria = sel_memoria;
  assign db_selMux      = sel_mux;

endmodule

// File: tb/tb_jogo_desafio_memoria.sv
// Testbench for jogo_desafio_memoria: scenario tasks with inline checks and a
// scoreboard queue of expected LED steps consumed as each step is displayed.
module tb_jogo_desafio_memoria;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic       chaveMemoria;
  logic       botaoDificuldade;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       ganhou, perdeu, pronto, timeout;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;
  logic       db_clock, db_iniciar, db_tem_jogada, db_igual, db_dificuldade, db_sel_memoria;
  logic [1:0] db_selMux;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  logic [3:0] rom1_m [16] = '{4'h1, 4'h4, 4'h2, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                              4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
  logic [3:0] rom0_m [16] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h1, 4'h2, 4'h4, 4'h8,
                              4'h2, 4'h8, 4'h4, 4'h1, 4'h8, 4'h1, 4'h2, 4'h4};

  jogo_desafio_memoria dut (
    .clock(clock), .reset(reset), .jogar(jogar), .chaveMemoria(chaveMemoria),
    .botaoDificuldade(botaoDificuldade), .botoes(botoes), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .timeout(timeout),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
    .db_jogadafeita(db_jogadafeita), .db_limite(db_limite), .db_clock(db_clock),
    .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada), .db_igual(db_igual),
    .db_dificuldade(db_dificuldade), .db_sel_memoria(db_sel_memoria),
    .db_selMux(db_selMux)
  );

  always #5 clock = ~clock;

  // Active-low gfedcba patterns.
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic int est();
    for (int c = 0; c < 16; c++)
      if (seg(4'(c)) == db_estado) return c;
    return -1;
  endfunction

  function automatic logic [3:0] rom_m(input logic sel, input int a);
    return sel ? rom1_m[a] : rom0_m[a];
  endfunction

  task automatic press(input logic [3:0] b);
    botoes = b;
    repeat (10) @(negedge clock);
    botoes = 4'b0000;
    repeat (3) @(negedge clock);
  endtask

  task automatic start_game(input logic sel, input logic dif);
    chaveMemoria     = sel;
    botaoDificuldade = dif;
    jogar = 1'b1;
    repeat (5) @(negedge clock);
    jogar = 1'b0;
  endtask

  // Plays back round r, popping an expected step at every entry into mostra;
  // returns at the first sample in espera.
  task automatic run_display(input int r, input logic sel);
    int  prev;
    int  s;
    bit  ok;
    logic [3:0] e;
    for (int i = 0; i <= r; i++) exp_q.push_back(rom_m(sel, i));
    prev = -1;
    ok   = 1'b0;
    for (int i = 0; i < (r + 1) * 1000 + 100; i++) begin
      @(negedge clock);
      s = est();
      if (s == 2 && prev != 2) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL display_extra_step round %0d: leds=%b, no step expected", r, leds);
        end else begin
          e = exp_q.pop_front();
          if (leds !== e) begin
            n_fail++;
            $display("FAIL display_step round %0d: leds=%b expected %b", r, leds, e);
          end
        end
      end
      if (s == 4) begin
        ok = 1'b1;
        break;
      end
      prev = s;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL display_reach_espera round %0d: state=%0d expected 4", r, est());
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL display_missing_steps round %0d: %0d left expected 0", r, exp_q.size());
    end
    exp_q.delete();
    n_checks++;
    if (db_limite !== seg(4'(r))) begin
      n_fail++;
      $display("FAIL db_limite round %0d: got %h expected %h", r, db_limite, seg(4'(r)));
    end
  endtask

  task automatic enter_plays(input int r, input logic sel, input int exp_final);
    for (int i = 0; i <= r; i++) begin
      press(rom_m(sel, i));
      if (i < r) begin
        n_checks++;
        if (est() != 4 || db_contagem !== seg(4'(i + 1))) begin
          n_fail++;
          $display("FAIL play_accept r%0d i%0d: state=%0d cont=%h expected 4/%h",
                   r, i, est(), db_contagem, seg(4'(i + 1)));
        end
      end else begin
        n_checks++;
        if (est() != exp_final || perdeu !== 1'b0) begin
          n_fail++;
          $display("FAIL round_end r%0d: state=%0d perdeu=%b expected %0d/0",
                   r, est(), perdeu, exp_final);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (est() != 0 || leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d leds=%b expected 0/0000", est(), leds);
    end
    n_checks++;
    if ({ganhou, perdeu, pronto, timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {ganhou, perdeu, pronto, timeout});
    end
    n_checks++;
    if (db_contagem !== seg(0) || db_limite !== seg(0) || db_jogadafeita !== seg(0)) begin
      n_fail++;
      $display("FAIL reset_debug: cont=%h lim=%h jog=%h expected %h",
               db_contagem, db_limite, db_jogadafeita, seg(0));
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (est() != 0) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d expected 0", est());
    end
  endtask

  task automatic test_display();
    int n_mostra = 0, n_lit = 0, n_apaga = 0, n_bad = 0, s = 0;
    chaveMemoria = 1'b1;
    botaoDificuldade = 1'b0;
    jogar = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clock);
      if (i == 4) jogar = 1'b0;
      s = est();
      if (s == 2) begin
        n_mostra++;
        if (leds == 4'b0001) n_lit++;
      end else if (s == 3) begin
        n_apaga++;
        if (leds != 4'b0000) n_bad++;
      end else if (s == 4) break;
    end
    n_checks++;
    if (n_mostra != 500 || n_lit != 500) begin
      n_fail++;
      $display("FAIL display_mostra: cycles=%0d lit=%0d expected 500/500", n_mostra, n_lit);
    end
    n_checks++;
    if (n_apaga != 500 || n_bad != 0) begin
      n_fail++;
      $display("FAIL display_apaga: cycles=%0d nonzero=%0d expected 500/0", n_apaga, n_bad);
    end
    n_checks++;
    if (s != 4 || db_contagem !== seg(0) || db_sel_memoria !== 1'b1) begin
      n_fail++;
      $display("FAIL display_end: state=%0d cont=%h sel=%b expected 4/%h/1",
               s, db_contagem, db_sel_memoria, seg(0));
    end
  endtask

  task automatic test_correct_rounds();
    enter_plays(0, 1'b1, 2);
    run_display(1, 1'b1);
    enter_plays(1, 1'b1, 2);
  endtask

  task automatic test_wrong_play();
    run_display(2, 1'b1);
    press(4'b0001);
    press(4'b0100);
    press(4'b0100);
    n_checks++;
    if (est() != 11 || perdeu !== 1'b1 || pronto !== 1'b1 || ganhou !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wrong_play: state=%0d g/p/pr/t=%b%b%b%b expected 11/0110",
               est(), ganhou, perdeu, pronto, timeout);
    end
    n_checks++;
    if (leds !== 4'b0000 || db_jogadafeita !== seg(4'h4)) begin
      n_fail++;
      $display("FAIL wrong_play_regs: leds=%b jog=%h expected 0000/%h", leds, db_jogadafeita, seg(4'h4));
    end
  endtask

  task automatic test_restart_reset();
    start_game(1'b1, 1'b0);
    n_checks++;
    if (est() != 2 || {ganhou, perdeu, pronto, timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL restart: state=%0d flags=%b expected 2/0000",
               est(), {ganhou, perdeu, pronto, timeout});
    end
    run_display(0, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (est() != 0 || leds !== 4'b0000 || db_contagem !== seg(0)) begin
      n_fail++;
      $display("FAIL midgame_reset: state=%0d leds=%b cont=%h expected 0/0000/%h",
               est(), leds, db_contagem, seg(0));
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int n = 1;
    start_game(1'b1, 1'b0);
    run_display(0, 1'b1);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      if (est() == 4) n++;
      else break;
    end
    n_checks++;
    if (n != 5000) begin
      n_fail++;
      $display("FAIL timeout_length: espera cycles=%0d expected 5000", n);
    end
    n_checks++;
    if (est() != 12 || timeout !== 1'b1 || perdeu !== 1'b1 || pronto !== 1'b1 ||
        ganhou !== 1'b0 || leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_flags: state=%0d g/p/pr/t=%b%b%b%b leds=%b expected 12/0111/0000",
               est(), ganhou, perdeu, pronto, timeout, leds);
    end
  endtask

  task automatic test_win();
    start_game(1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run_display(r, 1'b0);
      enter_plays(r, 1'b0, (r == 7) ? 10 : 2);
    end
    n_checks++;
    if (est() != 10 || ganhou !== 1'b1 || pronto !== 1'b1 || perdeu !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL win_flags: state=%0d g/p/pr/t=%b%b%b%b expected 10/1010",
               est(), ganhou, perdeu, pronto, timeout);
    end
    n_checks++;
    if (leds !== 4'b1111 || db_limite !== seg(4'h7)) begin
      n_fail++;
      $display("FAIL win_display: leds=%b lim=%h expected 1111/%h", leds, db_limite, seg(4'h7));
    end
  endtask

  initial begin
    reset = 1'b0;
    jogar = 1'b0;
    chaveMemoria = 1'b0;
    botaoDificuldade = 1'b0;
    botoes = 4'b0000;
    @(negedge clock);
    test_reset();
    test_display();
    test_correct_rounds();
    test_wrong_play();
    test_restart_reset();
    test_timeout();
    test_win();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
